// File: rtl/eviction_buffer.sv
// eviction_buffer: holds dirty lines evicted from L2 in a circular FIFO, serves
// combinational lookups for L2 misses, and drains one entry at a time to
// physical memory through a two-state write FSM.
// Optional build macro: EVICT_PERF_EN adds the wb_count and lookup_hit_count
// saturating performance counters.
module eviction_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alloc_valid,
    input  logic         alloc_dirty,
    input  logic [15:0]  alloc_addr,
    input  logic [255:0] alloc_data,
    output logic         alloc_ready,
    input  logic [15:0]  lookup_addr,
    output logic         lookup_hit,
    output logic [255:0] lookup_data,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp
`ifdef EVICT_PERF_EN
    ,
    output logic [15:0]  wb_count,
    output logic [15:0]  lookup_hit_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // Entry storage; addresses keep only the line-number bits [15:5].
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_dirty;
    logic [10:0]      r_addr [DEPTH];
    logic [255:0]     r_data [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    state_t           r_state;
    logic             r_pmem_write;
    logic [10:0]      r_pmem_line;
    logic [255:0]     r_pmem_wdata;

    logic             w_push;
    logic             w_pop;
    logic             w_hit;
    logic [255:0]     w_hit_data;
    logic             w_unused_lsbs;

    // Offset bits inside a line never take part in matching or storage.
    assign w_unused_lsbs = ^{alloc_addr[4:0], lookup_addr[4:0]};

    // Readiness depends only on the registered count, never on a same-cycle pop.
    assign alloc_ready = (r_count < CNT_W'(DEPTH));

    // Clean evictions are accepted but never stored.
    assign w_push = alloc_valid & alloc_ready & alloc_dirty;
    assign w_pop  = (r_state == ST_WRITE) & pmem_resp;

    // Search oldest to youngest so the youngest match (nearest tail) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        w_hit      = 1'b0;
        w_hit_data = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_head + PTR_W'(k);
            if (r_valid[idx] && r_dirty[idx] && (r_addr[idx] == lookup_addr[15:5])) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[idx];
            end
        end
    end

    assign lookup_hit   = w_hit;
    assign lookup_data  = w_hit_data;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = {r_pmem_line, 5'b0};
    assign pmem_wdata   = r_pmem_wdata;

    // Entry payload capture at the tail; payload needs no reset since valid gates it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= alloc_addr[15:5];
            r_data[r_tail] <= alloc_data;
        end
    end

    // FIFO bookkeeping: valid bits, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_dirty[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_dirty[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Drain FSM: latch the head entry on entry to WRITE and hold it until pmem_resp.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pmem_write <= 1'b0;
            r_pmem_line  <= '0;
            r_pmem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_count != '0) begin
                        r_state      <= ST_WRITE;
                        r_pmem_write <= 1'b1;
                        r_pmem_line  <= r_addr[r_head];
                        r_pmem_wdata <= r_data[r_head];
                    end
                end
                ST_WRITE: begin
                    if (pmem_resp) begin
                        r_state      <= ST_IDLE;
                        r_pmem_write <= 1'b0;
                        r_pmem_line  <= '0;
                        r_pmem_wdata <= '0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef EVICT_PERF_EN
    logic [15:0] r_wb_count;
    logic [15:0] r_lookup_hit_count;

    // Saturating counters of completed write-backs and cycles with a lookup hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_count         <= '0;
            r_lookup_hit_count <= '0;
        end else begin
            if (w_pop && (r_wb_count != 16'hFFFF)) begin
                r_wb_count <= r_wb_count + 16'd1;
            end
            if (w_hit && (r_lookup_hit_count != 16'hFFFF)) begin
                r_lookup_hit_count <= r_lookup_hit_count + 16'd1;
            end
        end
    end

    assign wb_count         = r_wb_count;
    assign lookup_hit_count = r_lookup_hit_count;
`endif

endmodule

// File: tb/tb_eviction_buffer.sv
// tb_eviction_buffer: directed spec scenarios plus randomized traffic against a
// queue-based reference model; write-backs are scored by a separate monitor.
module tb_eviction_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [15:0]  addr;
        logic [255:0] data;
    } line_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_valid;
    logic         alloc_dirty;
    logic [15:0]  alloc_addr;
    logic [255:0] alloc_data;
    logic         alloc_ready;
    logic [15:0]  lookup_addr;
    logic         lookup_hit;
    logic [255:0] lookup_data;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
`ifdef EVICT_PERF_EN
    logic [15:0]  wb_count;
    logic [15:0]  lookup_hit_count;
`endif

    eviction_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_dirty  (alloc_dirty),
        .alloc_addr   (alloc_addr),
        .alloc_data   (alloc_data),
        .alloc_ready  (alloc_ready),
        .lookup_addr  (lookup_addr),
        .lookup_hit   (lookup_hit),
        .lookup_data  (lookup_data),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp)
`ifdef EVICT_PERF_EN
        ,
        .wb_count         (wb_count),
        .lookup_hit_count (lookup_hit_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: resident lines oldest-first, and whether a write is outstanding.
    line_t m_q[$];
    line_t exp_wr_q[$];
    logic  m_wr;
    int    m_wb;
    int    m_hits;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [15:0] pool_addr();
        logic [15:0] a;
        a      = 16'h4000;
        a[7:5] = 3'($urandom_range(0, 5));
        a[4:0] = 5'($urandom_range(0, 31));
        return a;
    endfunction

    // Youngest resident line with the same line number wins.
    task automatic model_lookup(input logic [15:0] la, output logic hit, output logic [255:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = 0; i < m_q.size(); i++) begin
            if (m_q[i].addr[15:5] == la[15:5]) begin
                hit = 1'b1;
                d   = m_q[i].data;
            end
        end
    endtask

    // One clock cycle: drive, check current outputs against the model, advance the model.
    task automatic step(input logic av, input logic ad, input logic [15:0] aa,
                        input logic [255:0] adat, input logic [15:0] la, input logic resp);
        logic         hit;
        logic [255:0] d;
        logic         acc;
        logic         pop;
        logic         nxt_wr;
        line_t        ln;
        @(negedge clk);
        alloc_valid = av;
        alloc_dirty = ad;
        alloc_addr  = aa;
        alloc_data  = adat;
        lookup_addr = la;
        pmem_resp   = resp;
        #1;
        model_lookup(la, hit, d);
        chk("alloc_ready", alloc_ready, m_q.size() < DEPTH);
        chk("lookup_hit", lookup_hit, hit);
        chk("lookup_data", lookup_data, d);
        chk("pmem_write", pmem_write, m_wr);
        if (m_wr && m_q.size() > 0) begin
            chk("pmem_address", pmem_address, m_q[0].addr);
            chk("pmem_wdata", pmem_wdata, m_q[0].data);
        end
`ifdef EVICT_PERF_EN
        chk("wb_count", wb_count, m_wb);
        chk("lookup_hit_count", lookup_hit_count, m_hits);
`endif
        acc    = av && ad && (m_q.size() < DEPTH);
        pop    = m_wr && resp;
        nxt_wr = m_wr ? !resp : (m_q.size() > 0);
        if (pop) begin
            void'(m_q.pop_front());
            m_wb++;
        end
        if (hit) m_hits++;
        if (acc) begin
            ln.addr = {aa[15:5], 5'b0};
            ln.data = adat;
            m_q.push_back(ln);
            exp_wr_q.push_back(ln);
        end
        m_wr = nxt_wr;
    endtask

    task automatic idle(input logic [15:0] la, input logic resp);
        step(1'b0, 1'b0, 16'h0, '0, la, resp);
    endtask

    task automatic do_reset(input logic resp);
        @(negedge clk);
        rst         = 1'b1;
        alloc_valid = 1'($urandom);
        alloc_dirty = 1'b1;
        alloc_addr  = pool_addr();
        alloc_data  = rand256();
        lookup_addr = pool_addr();
        pmem_resp   = resp;
        @(posedge clk);
        m_q.delete();
        exp_wr_q.delete();
        m_wr   = 1'b0;
        m_wb   = 0;
        m_hits = 0;
        @(negedge clk);
        rst         = 1'b0;
        alloc_valid = 1'b0;
        pmem_resp   = 1'b0;
        lookup_addr = 16'h0;
        #1;
        chk("rst_alloc_ready", alloc_ready, 1'b1);
        chk("rst_lookup_hit", lookup_hit, 1'b0);
        chk("rst_lookup_data", lookup_data, '0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_pmem_address", pmem_address, 16'h0);
        chk("rst_pmem_wdata", pmem_wdata, '0);
`ifdef EVICT_PERF_EN
        chk("rst_wb_count", wb_count, 16'h0);
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (m_q.size() == 0 && !m_wr) break;
            idle(pool_addr(), 1'b1);
        end
        idle(16'h0, 1'b0);
        chk("drain_left", 256'(exp_wr_q.size()), 256'd0);
    endtask

    // Write-back monitor: every completed handshake must match the next expected line.
    always begin
        line_t e;
        @(negedge clk);
        #2;
        if (!rst && pmem_write && pmem_resp) begin
            if (exp_wr_q.size() == 0) begin
                n_chk++;
                $display("FAIL wr_unexpected: got write to %0h expected no write", pmem_address);
            end else begin
                e = exp_wr_q.pop_front();
                chk("wr_addr", pmem_address, e.addr);
                chk("wr_data", pmem_wdata, e.data);
            end
        end
    end

    initial begin
        logic [255:0] a5;
        a5          = {32{8'hA5}};
        rst         = 1'b1;
        alloc_valid = 1'b0;
        alloc_dirty = 1'b0;
        alloc_addr  = '0;
        alloc_data  = '0;
        lookup_addr = '0;
        pmem_resp   = 1'b0;
        m_wr        = 1'b0;
        m_wb        = 0;
        m_hits      = 0;
        repeat (2) @(posedge clk);
        do_reset(1'b0);

        // Dirty alloc becomes visible next cycle; write starts the cycle after.
        step(1'b1, 1'b1, 16'h1240, a5, 16'h125F, 1'b0);
        chk("t42_same_cycle_hit", lookup_hit, 1'b0);
        idle(16'h125F, 1'b0);
        chk("t42_hit", lookup_hit, 1'b1);
        chk("t42_data", lookup_data, a5);
        chk("t42_no_write_yet", pmem_write, 1'b0);
        idle(16'h125F, 1'b0);
        chk("t42_write", pmem_write, 1'b1);
        chk("t42_address", pmem_address, 16'h1240);
        drain();

        // Clean alloc is discarded.
        do_reset(1'b0);
        step(1'b1, 1'b0, 16'h2000, rand256(), 16'h2000, 1'b0);
        idle(16'h2000, 1'b0);
        chk("t43_hit", lookup_hit, 1'b0);
        idle(16'h2000, 1'b0);
        chk("t43_write", pmem_write, 1'b0);

        // Fill, ignored 5th alloc, simultaneous alloc and pop while full, FIFO order.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 16'h5000 + 16'(i * 32), 256'(i + 1), 16'h5000, 1'b0);
        step(1'b1, 1'b1, 16'h6000, 256'h55, 16'h6000, 1'b0);
        chk("t44_full", alloc_ready, 1'b0);
        step(1'b1, 1'b1, 16'h6020, 256'h66, 16'h6020, 1'b1);
        chk("t46_full_at_pop", alloc_ready, 1'b0);
        step(1'b1, 1'b1, 16'h7000, 256'h77, 16'h5000, 1'b0);
        chk("t44_ready_after_pop", alloc_ready, 1'b1);
        chk("t46_popped_hidden", lookup_hit, 1'b0);
        idle(16'h7000, 1'b0);
        chk("t46_full_again", alloc_ready, 1'b0);
        drain();

        // Duplicate line: lookup returns the younger copy, write-back order keeps the older first.
        do_reset(1'b0);
        step(1'b1, 1'b1, 16'h3000, 256'd1, 16'h3000, 1'b0);
        step(1'b1, 1'b1, 16'h3000, 256'd2, 16'h3000, 1'b0);
        idle(16'h3000, 1'b0);
        chk("t45_youngest", lookup_data, 256'd2);
        drain();

        // Reset in the middle of a write.
        step(1'b1, 1'b1, 16'h8000, rand256(), 16'h8000, 1'b0);
        step(1'b1, 1'b1, 16'h8020, rand256(), 16'h8000, 1'b0);
        idle(16'h8000, 1'b0);
        chk("t47_writing", pmem_write, 1'b1);
        do_reset(1'b1);
        idle(16'h8000, 1'b0);
        chk("t47_no_write", pmem_write, 1'b0);
        chk("t47_dropped", lookup_hit, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset(1'($urandom));
            end else begin
                step($urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0, pool_addr(),
                     rand256(), pool_addr(), 1'($urandom));
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/eviction_buffer.md
EVICTION_BUFFER -- requirements
Module: eviction_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of entries (power of two, 2..8).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 alloc_valid  in  1  L2 presents an evicted line this cycle.
REQ-005 alloc_dirty  in  1  evicted line is dirty.
REQ-006 alloc_addr  in  16  line address; bits [4:0] ignored.
REQ-007 alloc_data  in  256  evicted cacheline.
REQ-008 alloc_ready  out  1  buffer can accept an alloc this cycle.
REQ-009 lookup_addr  in  16  L2 miss address to search.
REQ-010 lookup_hit  out  1  a valid entry matches lookup_addr[15:5].
REQ-011 lookup_data  out  256  data of the matching entry.
REQ-012 pmem_write  out  1  write request to physical memory.
REQ-013 pmem_address  out  16  write address, bits [4:0] driven 0.
REQ-014 pmem_wdata  out  256  write data.
REQ-015 pmem_resp  in  1  physical memory write complete.

Function
REQ-016 Storage SHALL be a DEPTH-entry circular FIFO of {valid, dirty, addr, data} entries with head, tail and a count of width log2(DEPTH)+1.
REQ-017 alloc_ready SHALL be 1 iff count < DEPTH; this is purely a function of registered count, with no same-cycle pop forwarding.
REQ-018 alloc_valid & alloc_ready & alloc_dirty SHALL write the entry at tail, set valid=1 and dirty=1, advance tail modulo DEPTH and increment count, all at the next edge.
REQ-019 alloc_valid & alloc_ready & !alloc_dirty SHALL be accepted and discarded, with no state change.
REQ-020 alloc_valid while alloc_ready=0 SHALL be ignored; L2 SHALL hold the request.
REQ-021 Lookup SHALL be combinational over all valid entries, comparing addr[15:5].
REQ-022 On multiple matches, lookup_data SHALL come from the youngest entry, nearest tail.
REQ-023 lookup_data SHALL be 0 when lookup_hit=0.
REQ-024 A line being allocated in the same cycle SHALL NOT be visible to lookup until the next cycle.
REQ-025 Lookup SHALL NOT remove or modify entries.
REQ-026 The drain FSM SHALL have two states, IDLE and WRITE.
REQ-027 IDLE->WRITE SHALL occur on the edge after count > 0.
REQ-028 In WRITE, pmem_write=1 and pmem_address/pmem_wdata SHALL be taken from the head entry and held stable until pmem_resp.
REQ-029 In WRITE with pmem_resp=1, the head entry SHALL be cleared (valid=0), head SHALL advance modulo DEPTH, count SHALL decrement, and the FSM SHALL go to IDLE.
REQ-030 pmem_write SHALL be 0 in IDLE, giving at least one idle cycle between writes.
REQ-031 Simultaneous accepted alloc and completed pop SHALL leave count unchanged and update both head and tail.
REQ-032 The entry being drained SHALL remain visible to lookup until the edge on which pmem_resp is sampled.
REQ-033 count SHALL never exceed DEPTH or go below 0.
REQ-034 Head and tail SHALL wrap from DEPTH-1 to 0.

Reset
REQ-035 rst SHALL clear all valid bits, head, tail and count, and force the FSM to IDLE.
REQ-036 After rst, outputs SHALL be: alloc_ready=1, lookup_hit=0, lookup_data=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
REQ-037 rst asserted during WRITE SHALL abandon the write and drop all entries; any pmem_resp in that cycle SHALL be ignored.
REQ-038 rst SHALL take priority over alloc and pop in the same cycle.

Configuration
REQ-039 Macro EVICT_PERF_EN, when defined, SHALL add outputs wb_count (16 bit) and lookup_hit_count (16 bit), both saturating at 16'hFFFF and cleared by rst.
REQ-040 wb_count SHALL increment once per completed pop; lookup_hit_count SHALL increment per cycle with lookup_hit=1.
REQ-041 Without EVICT_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-042 Dirty alloc addr=16'h1240, data=256'hA5.. with pmem_resp held 0 -> next cycle lookup_addr=16'h125F gives hit=1 and data=A5..; pmem_write=1 with pmem_address=16'h1240 from the following cycle.
REQ-043 Clean alloc addr=16'h2000 -> count stays 0, pmem_write stays 0, lookup 16'h2000 gives hit=0.
REQ-044 Fill 4 dirty lines with pmem_resp=0 -> alloc_ready=0; a 5th alloc is ignored; one pmem_resp -> alloc_ready=1 next cycle; 4 writes appear in FIFO order.
REQ-045 Two dirty allocs to 16'h3000 with data 1 then 2 -> lookup returns 2; first pmem write carries 1.
REQ-046 Full buffer, alloc and pmem_resp in the same cycle -> alloc ignored, count=3.
REQ-047 rst mid-WRITE -> pmem_write=0 and count=0 next cycle; with EVICT_PERF_EN, wb_count=0.
